// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - single-bus 32-bit CPU datapath with register file, ALU, 512x32 RAM and branch condition
module cpu_datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic        IncPC,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        Gra, Grb, Grc, Rin, Rout, BAout,
    input  logic        MARin, MDRout, MDRin, memRead, ramEnable,
    input  logic        PCin, PCout, ADD, Zin, Zhighout, Zlowout,
    input  logic        HIin, LOin, HIout, LOout, Yin, IRin, Cout, CONin,
    input  logic [31:0] InPortData,
    input  logic        InPort_Out,
    output logic [31:0] OutPortData,
    input  logic        OutPort_In,
    output logic        CON
);

    logic [31:0] r_regs [16];
    logic [31:0] r_pc, r_ir, r_mdr, r_y, r_hi, r_lo, r_outport;
    logic [63:0] r_z;
    logic [8:0]  r_mar;
    logic        r_con;
    logic [31:0] r_mem [512];

    logic [15:0] w_rout, w_rin;
    logic [3:0]  w_sel;
    logic [31:0] w_c;
    logic [31:0] w_bus;
    logic [63:0] w_alu;
    logic        w_cond;
    logic        w_unused_opcode;

    assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    assign w_sel = ({4{Gra}} & r_ir[26:23]) | ({4{Grb}} & r_ir[22:19]) | ({4{Grc}} & r_ir[18:15]);
    assign w_c   = {{13{r_ir[18]}}, r_ir[18:0]};
    assign w_unused_opcode = ^r_ir[31:27];

    // Descending scan so the lowest-numbered asserted Rnout wins.
    always_comb begin
        w_bus = '0;
        if (|w_rout) begin
            for (int i = 15; i >= 0; i--) begin
                if (w_rout[i]) w_bus = r_regs[i];
            end
        end else if (Rout) begin
            w_bus = r_regs[w_sel];
        end else if (BAout) begin
            w_bus = (w_sel == 4'd0) ? 32'd0 : r_regs[w_sel];
        end else if (PCout) begin
            w_bus = r_pc;
        end else if (MDRout) begin
            w_bus = r_mdr;
        end else if (Zhighout) begin
            w_bus = r_z[63:32];
        end else if (Zlowout) begin
            w_bus = r_z[31:0];
        end else if (HIout) begin
            w_bus = r_hi;
        end else if (LOout) begin
            w_bus = r_lo;
        end else if (Cout) begin
            w_bus = w_c;
        end else if (InPort_Out) begin
            w_bus = InPortData;
        end
    end

    assign w_alu = ADD ? ({32'd0, r_y} + {32'd0, w_bus}) : {32'd0, w_bus};

    always_comb begin
        case (r_ir[20:19])
            2'b00:   w_cond = (w_bus == 32'd0);
            2'b01:   w_cond = (w_bus != 32'd0);
            2'b10:   w_cond = !w_bus[31] && (w_bus != 32'd0);
            default: w_cond = w_bus[31];
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
            r_pc      <= '0;
            r_ir      <= '0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_outport <= '0;
            r_con     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_rin[i] || (Rin && (w_sel == 4'(i)))) r_regs[i] <= w_bus;
            end
            if (PCin)            r_pc <= w_bus;
            else if (IncPC)      r_pc <= r_pc + 32'd1;
            if (IRin)            r_ir <= w_bus;
            if (MARin)           r_mar <= w_bus[8:0];
            if (MDRin)           r_mdr <= memRead ? r_mem[r_mar] : w_bus;
            if (Yin)             r_y <= w_bus;
            if (Zin)             r_z <= w_alu;
            if (HIin)            r_hi <= w_bus;
            if (LOin)            r_lo <= w_bus;
            if (OutPort_In)      r_outport <= w_bus;
            if (CONin)           r_con <= w_cond;
        end
    end

    // RAM has no reset so its contents survive clear.
    always_ff @(posedge clock) begin
        if (ramEnable) r_mem[r_mar] <= r_mdr;
    end

    assign OutPortData = r_outport;
    assign CON         = r_con;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - self-checking bench for cpu_datapath
module tb_cpu_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic        IncPC;
    logic [15:0] rout, rin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        MARin, MDRout, MDRin, memRead, ramEnable;
    logic        PCin, PCout, ADD, Zin, Zhighout, Zlowout;
    logic        HIin, LOin, HIout, LOout, Yin, IRin, Cout, CONin;
    logic [31:0] InPortData;
    logic        InPort_Out, OutPort_In;
    wire  [31:0] OutPortData;
    wire         CON;

    int n_checks = 0;
    int n_err = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mdr, m_y, m_hi, m_lo, m_out;
    logic [63:0] m_z;
    logic [8:0]  m_mar;
    logic        m_con;
    logic [31:0] m_mem [512];
    bit          m_valid [512];

    always #5 clock = ~clock;

    cpu_datapath dut (
        .clock(clock), .clear(clear), .IncPC(IncPC),
        .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
        .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
        .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
        .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
        .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .MARin(MARin), .MDRout(MDRout), .MDRin(MDRin), .memRead(memRead), .ramEnable(ramEnable),
        .PCin(PCin), .PCout(PCout), .ADD(ADD), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Yin(Yin), .IRin(IRin),
        .Cout(Cout), .CONin(CONin), .InPortData(InPortData), .InPort_Out(InPort_Out),
        .OutPortData(OutPortData), .OutPort_In(OutPort_In), .CON(CON)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        clear = 1'b1; IncPC = 0; rout = '0; rin = '0;
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        MARin = 0; MDRout = 0; MDRin = 0; memRead = 0; ramEnable = 0;
        PCin = 0; PCout = 0; ADD = 0; Zin = 0; Zhighout = 0; Zlowout = 0;
        HIin = 0; LOin = 0; HIout = 0; LOout = 0; Yin = 0; IRin = 0; Cout = 0; CONin = 0;
        InPortData = '0; InPort_Out = 0; OutPort_In = 0;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = 0; m_ir = 0; m_mdr = 0; m_y = 0; m_hi = 0; m_lo = 0; m_out = 0;
        m_z = 0; m_mar = 0; m_con = 0;
    endfunction

    function automatic logic [3:0] model_sel();
        return (Gra ? m_ir[26:23] : 4'd0) | (Grb ? m_ir[22:19] : 4'd0) | (Grc ? m_ir[18:15] : 4'd0);
    endfunction

    function automatic logic [31:0] model_bus();
        logic [3:0] s;
        s = model_sel();
        for (int i = 0; i < 16; i++) if (rout[i]) return m_r[i];
        if (Rout)       return m_r[s];
        if (BAout)      return (s == 0) ? 32'd0 : m_r[s];
        if (PCout)      return m_pc;
        if (MDRout)     return m_mdr;
        if (Zhighout)   return m_z[63:32];
        if (Zlowout)    return m_z[31:0];
        if (HIout)      return m_hi;
        if (LOout)      return m_lo;
        if (Cout)       return 32'($signed(m_ir[18:0]));
        if (InPort_Out) return InPortData;
        return 32'd0;
    endfunction

    function automatic void model_clock();
        logic [31:0] b, rd;
        logic [3:0]  s;
        logic [63:0] sum;
        logic        cond;
        b = model_bus();
        s = model_sel();
        sum = ADD ? (64'(m_y) + 64'(b)) : 64'(b);
        case (m_ir[20:19])
            2'b00: cond = (b == 0);
            2'b01: cond = (b != 0);
            2'b10: cond = ($signed(b) > 0);
            2'b11: cond = ($signed(b) < 0);
        endcase
        rd = m_mem[m_mar];
        if (ramEnable) begin m_mem[m_mar] = m_mdr; m_valid[m_mar] = 1; end
        for (int i = 0; i < 16; i++) if (rin[i] || (Rin && s == i)) m_r[i] = b;
        if (PCin) m_pc = b; else if (IncPC) m_pc = m_pc + 1;
        if (IRin) m_ir = b;
        if (MARin) m_mar = b[8:0];
        if (MDRin) m_mdr = memRead ? rd : b;
        if (Yin) m_y = b;
        if (Zin) m_z = sum;
        if (HIin) m_hi = b;
        if (LOin) m_lo = b;
        if (OutPort_In) m_out = b;
        if (CONin) m_con = cond;
    endfunction

    task automatic step();
        if (!clear) model_reset(); else model_clock();
        @(posedge clock); #1;
    endtask

    task automatic put(input logic [31:0] v);
        InPort_Out = 1; InPortData = v;
    endtask

    // 0-15 Rn, 16 PC, 17 MDR, 18 Zhigh, 19 Zlow, 20 HI, 21 LO, 22 C
    task automatic observe(input int src, input logic [31:0] exp, input string name);
        idle();
        if (src < 16) rout[src] = 1;
        case (src)
            16: PCout = 1;   17: MDRout = 1; 18: Zhighout = 1; 19: Zlowout = 1;
            20: HIout = 1;   21: LOout = 1;  22: Cout = 1;
            default: ;
        endcase
        OutPort_In = 1;
        step();
        check(name, 64'(OutPortData), 64'(exp));
    endtask

    typedef struct { logic [1:0] c2; logic [31:0] bus; logic exp; } con_vec_t;
    typedef struct { logic [31:0] y; logic [31:0] b; logic [63:0] exp; } add_vec_t;

    initial begin
        con_vec_t cv [9];
        add_vec_t av [4];
        cv[0] = '{2'b01, 32'h0, 1'b0};        cv[1] = '{2'b01, 32'h3, 1'b1};
        cv[2] = '{2'b11, 32'h80000000, 1'b1}; cv[3] = '{2'b00, 32'h0, 1'b1};
        cv[4] = '{2'b00, 32'h5, 1'b0};        cv[5] = '{2'b10, 32'h5, 1'b1};
        cv[6] = '{2'b10, 32'h80000001, 1'b0}; cv[7] = '{2'b10, 32'h0, 1'b0};
        cv[8] = '{2'b11, 32'h7FFFFFFF, 1'b0};
        av[0] = '{32'd5, 32'd7, 64'd12};
        av[1] = '{32'hFFFFFFFF, 32'd1, 64'h1_00000000};
        av[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1_FFFFFFFE};
        av[3] = '{32'd0, 32'd0, 64'd0};
        for (int i = 0; i < 512; i++) m_valid[i] = 0;
        model_reset();

        idle(); clear = 0; step(); step();
        check("reset_out", 64'(OutPortData), 64'd0);
        check("reset_con", 64'(CON), 64'd0);
        observe(0, 32'd0, "reset_r0");
        observe(16, 32'd0, "reset_pc");

        idle(); put(32'h100); rin[6] = 1; step();
        idle(); PCout = 1; MARin = 1; IncPC = 1; step();
        idle(); put(32'hAB000000); IRin = 1; step();
        idle(); PCout = 1; rin[15] = 1; step();
        idle(); Gra = 1; Rout = 1; PCin = 1; step();
        observe(6, 32'h100, "jal_r6");
        observe(15, 32'd1, "jal_r15");
        observe(16, 32'h100, "jal_pc");

        #2 clear = 0; #1;
        check("async_out", 64'(OutPortData), 64'd0);
        model_reset();
        #1 idle();
        observe(16, 32'd0, "async_pc");

        idle(); put(32'd5); rin[1] = 1; step();
        idle(); put(32'd7); rin[2] = 1; step();
        idle(); rout[1] = 1; Yin = 1; step();
        idle(); rout[2] = 1; ADD = 1; Zin = 1; step();
        idle(); Zlowout = 1; rin[3] = 1; step();
        observe(3, 32'd12, "add_r3");
        observe(18, 32'd0, "add_zhigh");

        for (int i = 0; i < 4; i++) begin
            idle(); put(av[i].y); Yin = 1; step();
            idle(); put(av[i].b); ADD = 1; Zin = 1; step();
            observe(18, av[i].exp[63:32], $sformatf("addtab%0d_hi", i));
            observe(19, av[i].exp[31:0], $sformatf("addtab%0d_lo", i));
        end

        idle(); put(32'h10); MARin = 1; step();
        idle(); put(32'hDEADBEEF); MDRin = 1; step();
        idle(); ramEnable = 1; step();
        idle(); put(32'h0); MDRin = 1; step();
        idle(); MDRin = 1; memRead = 1; step();
        idle(); MDRout = 1; rin[4] = 1; step();
        observe(4, 32'hDEADBEEF, "mem_r4");

        idle(); put(32'd9); rin[0] = 1; step();
        idle(); put(32'h0); IRin = 1; step();
        idle(); Grb = 1; BAout = 1; rin[5] = 1; step();
        observe(5, 32'd0, "baout_r5");
        idle(); Grb = 1; Rout = 1; rin[5] = 1; step();
        observe(5, 32'd9, "rout_r5");

        for (int i = 0; i < 9; i++) begin
            idle(); put(32'(cv[i].c2) << 19); IRin = 1; step();
            idle(); put(cv[i].bus); CONin = 1; step();
            check($sformatf("contab%0d", i), 64'(CON), 64'(cv[i].exp));
        end

        idle(); put(32'h00040005); IRin = 1; step();
        observe(22, 32'hFFFC0005, "c_sext");
        idle(); put(32'hFFFFFFFF); PCin = 1; step();
        idle(); IncPC = 1; step();
        observe(16, 32'd0, "pc_wrap");
        idle(); put(32'h55); PCin = 1; IncPC = 1; step();
        observe(16, 32'h55, "pcin_wins");
        idle(); put(32'hA); rin[3] = 1; step();
        idle(); put(32'h1234); rout[3] = 1; rout[7] = 1; PCout = 1; OutPort_In = 1; step();
        check("bus_priority", 64'(OutPortData), 64'hA);
        idle(); OutPort_In = 1; step();
        check("bus_idle_zero", 64'(OutPortData), 64'd0);

        for (int n = 0; n < 400; n++) begin
            idle();
            clear = ($urandom_range(0, 63) != 0);
            for (int i = 0; i < 16; i++) begin
                rout[i] = ($urandom_range(0, 19) == 0);
                rin[i]  = ($urandom_range(0, 9) == 0);
            end
            IncPC = ($urandom_range(0, 7) == 0); Gra = ($urandom_range(0, 3) == 0);
            Grb = ($urandom_range(0, 3) == 0);   Grc = ($urandom_range(0, 3) == 0);
            Rin = ($urandom_range(0, 7) == 0);   Rout = ($urandom_range(0, 7) == 0);
            BAout = !Rout && ($urandom_range(0, 7) == 0);
            MARin = ($urandom_range(0, 7) == 0); MDRout = ($urandom_range(0, 7) == 0);
            MDRin = ($urandom_range(0, 7) == 0); ramEnable = ($urandom_range(0, 7) == 0);
            memRead = m_valid[m_mar] && ($urandom_range(0, 1) == 0);
            PCin = ($urandom_range(0, 7) == 0);  PCout = ($urandom_range(0, 7) == 0);
            ADD = ($urandom_range(0, 1) == 0);   Zin = ($urandom_range(0, 5) == 0);
            Zhighout = ($urandom_range(0, 7) == 0); Zlowout = ($urandom_range(0, 7) == 0);
            HIin = ($urandom_range(0, 7) == 0);  LOin = ($urandom_range(0, 7) == 0);
            HIout = ($urandom_range(0, 7) == 0); LOout = ($urandom_range(0, 7) == 0);
            Yin = ($urandom_range(0, 5) == 0);   IRin = ($urandom_range(0, 5) == 0);
            Cout = ($urandom_range(0, 7) == 0);  CONin = ($urandom_range(0, 3) == 0);
            InPort_Out = ($urandom_range(0, 2) == 0); InPortData = $urandom();
            OutPort_In = ($urandom_range(0, 1) == 0);
            step();
            check($sformatf("rand%0d_out", n), 64'(OutPortData), 64'(m_out));
            check($sformatf("rand%0d_con", n), 64'(CON), 64'(m_con));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; every register loads on its rising edge.
REQ-002 SHALL have port clear, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports IncPC, input, 1, PC increment enable.
REQ-004 SHALL have ports R0out..R15out, input, 1 each, drive Rn onto bus.
REQ-005 SHALL have ports R0in..R15in, input, 1 each, load Rn from bus.
REQ-006 SHALL have ports Gra, Grb, Grc, Rin, Rout, BAout, input, 1 each, IR-field register select and enables.
REQ-007 SHALL have ports MARin, MDRout, MDRin, memRead, ramEnable, input, 1 each, memory path controls.
REQ-008 SHALL have ports PCin, PCout, ADD, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout, Yin, IRin, Cout, CONin, input, 1 each, register and ALU controls.
REQ-009 SHALL have port InPortData, input, 32, external input word; port InPort_Out, input, 1, drive InPortData onto bus.
REQ-010 SHALL have port OutPortData, output, 32, OutPort register value; port OutPort_In, input, 1, load OutPort from bus.
REQ-011 SHALL have port CON, output, 1, branch-condition flip-flop.

Function
REQ-012 SHALL contain one 32-bit bus, driven by exactly one selected source per cycle; if none is selected, bus = 0.
REQ-013 If several sources are selected, the bus SHALL take the first in this order: R0..R15 (individual), Rout/BAout select, PC, MDR, Zhigh, Zlow, HI, LO, C, InPort.
REQ-014 SHALL hold 32-bit registers R0-R15, PC, IR, MDR, Y, HI, LO, OutPort; a 64-bit Z; a 9-bit MAR; a 1-bit CON.
REQ-015 SHALL decode IR as opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=sign-extended IR[18:0].
REQ-016 Select logic SHALL choose Ra/Rb/Rc via Gra/Grb/Grc (OR of the selected fields). Rin loads the selected register; Rout or BAout drives it onto the bus.
REQ-017 With BAout and selected register R0, the bus SHALL be 0; with Rout, the bus SHALL be the R0 contents.
REQ-018 Cout SHALL drive C onto the bus.
REQ-019 On each clock edge, each register with its in-enable asserted SHALL load the bus; MAR SHALL load bus[8:0].
REQ-020 If IncPC is asserted and PCin is not, PC SHALL become PC+1 (mod 2^32); if PCin is asserted, PCin SHALL win.
REQ-021 The ALU SHALL be combinational: with ADD asserted, result = Y + bus (64-bit zero-extended, carry in bit 32); with ADD deasserted, result = {32'b0, bus}. Zin SHALL load the result into Z.
REQ-022 Zhighout SHALL drive Z[63:32] onto the bus; Zlowout SHALL drive Z[31:0].
REQ-023 SHALL contain a 512x32 synchronous RAM addressed by MAR. With ramEnable, mem[MAR] SHALL be written with MDR on the clock edge.
REQ-024 MDRin SHALL load MDR with mem[MAR] when memRead is asserted, else with the bus.
REQ-025 With CONin, CON SHALL load the condition evaluated on the bus, selected by IR[20:19]: 00 bus==0; 01 bus!=0; 10 bus[31]==0 and bus!=0; 11 bus[31]==1.
REQ-026 OutPortData SHALL equal the OutPort register at all times.

Reset
REQ-027 While clear=0, all registers (R0-R15, PC, IR, MAR, MDR, Y, Z, HI, LO, OutPort, CON) SHALL be 0 immediately, regardless of clock.
REQ-028 RAM contents SHALL NOT be affected by clear.
REQ-029 After clear deasserts, the first rising edge SHALL operate normally.

Verification
REQ-030 JAL: reset; InPortData=0x100 with InPort_Out+R6in → R6=0x100. PCout+MARin+IncPC → MAR=0, PC=1. InPortData=0xAB000000 with InPort_Out+IRin → IR loaded, Ra=6. PCout+R15in → R15=1. Gra+Rout+PCin → PC=0x100.
REQ-031 ADD: R1=5, R2=7. R1out+Yin, then R2out+ADD+Zin, then Zlowout+R3in → R3=12, Zhigh=0. Y=0xFFFFFFFF plus bus 1 → Z=0x1_00000000.
REQ-032 Memory: MAR=0x10, MDR=0xDEADBEEF, ramEnable → write. Then MDRin+memRead → MDR=0xDEADBEEF; MDRout+R4in → R4=0xDEADBEEF.
REQ-033 CON: IR[20:19]=01, bus=0 with CONin → CON=0; bus=3 → CON=1. IR[20:19]=11, bus=0x80000000 → CON=1.
REQ-034 BAout: R0=9, IR Rb=0. Grb+BAout+R5in → R5=0; Grb+Rout+R5in → R5=9.
REQ-035 Async reset: drive clear low mid-cycle with PC=0x100 → PC=0 before the next edge; OutPortData=0.
